// File: rtl/prog_clk_divider.sv
// Runtime-programmable clock divider: near-50% divided clock plus a one-cycle tick per period.
// Ratio reloads are held pending and applied only at a period boundary or on restart.
module prog_clk_divider #(
    parameter int unsigned     WIDTH       = 32,
    parameter longint unsigned DEFAULT_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    output logic             clk_n,
    output logic             tick,
    output logic [WIDTH-1:0] div_active,
    output logic             pending,
    output logic             load_err
);

    localparam longint unsigned DIV_MAX   = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

    if ((DEFAULT_DIV < 64'd2) || (DEFAULT_DIV > DIV_MAX)) begin : g_bad_default_div
        $error("prog_clk_divider: DEFAULT_DIV must lie in 2 .. 2**WIDTH-1");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_pend_nx;
    logic [WIDTH-1:0] div_active_nx;
    logic [WIDTH-1:0] high_start;
    logic             clk_n_nx;
    logic             tick_nx;
    logic             pending_nx;
    logic             load_err_nx;
    logic             load_ok;
    logic             wrap;

    // Next-state logic; priority is restart over wrap/count, rst handled in the register.
    always_comb begin
        load_ok       = div_load && (div_in >= WIDTH'(2));
        wrap          = (cnt == div_active - WIDTH'(1));
        cnt_inc       = cnt + WIDTH'(1);
        high_start    = div_active - (div_active >> 1);
        cnt_nx        = cnt;
        clk_n_nx      = clk_n;
        tick_nx       = 1'b0;
        div_active_nx = div_active;
        div_pend_nx   = div_pend;
        pending_nx    = pending;
        load_err_nx   = div_load && !load_ok;

        if (restart) begin
            cnt_nx   = '0;
            clk_n_nx = 1'b0;
            if (load_ok) begin
                div_active_nx = div_in;
                div_pend_nx   = div_in;
                pending_nx    = 1'b0;
            end else if (pending) begin
                div_active_nx = div_pend;
                pending_nx    = 1'b0;
            end
        end else begin
            if (en) begin
                if (wrap) begin
                    cnt_nx   = '0;
                    tick_nx  = 1'b1;
                    clk_n_nx = 1'b0;
                    if (pending) begin
                        div_active_nx = div_pend;
                        pending_nx    = 1'b0;
                    end
                end else begin
                    cnt_nx   = cnt_inc;
                    clk_n_nx = (cnt_inc >= high_start);
                end
            end
            // A load coinciding with a wrap becomes pending for the following wrap.
            if (load_ok) begin
                div_pend_nx = div_in;
                pending_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            clk_n      <= 1'b0;
            tick       <= 1'b0;
            div_active <= DIV_RESET;
            div_pend   <= DIV_RESET;
            pending    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            clk_n      <= clk_n_nx;
            tick       <= tick_nx;
            div_active <= div_active_nx;
            div_pend   <= div_pend_nx;
            pending    <= pending_nx;
            load_err   <= load_err_nx;
        end
    end

endmodule
